// File: rtl/pulse_sel_pkg.sv
// Shared definitions for the pulse selector: FSM state encoding, default
// channel count/width, and a helper for index-port widths.
package pulse_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam int N_DEFAULT = 4;
  localparam int W_DEFAULT = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_sel_n_if.sv
// Channel-side bundle of the pulse selector: per-channel data/valid in,
// shared ready, output pulse and selected index out.
interface pulse_sel_n_if
  import pulse_sel_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
);

  localparam int IW = idx_width(N);

  logic [N-1:0]   dav_;
  logic [N*W-1:0] x;
  logic           mode;
  logic           rfd;
  logic           out;
  logic [IW-1:0]  sel_idx;

  modport master (
    output dav_, x, mode,
    input  rfd, out, sel_idx
  );

  modport slave (
    input  dav_, x, mode,
    output rfd, out, sel_idx
  );

endinterface

// File: rtl/sel_n.sv
// Combinational max/min selector over N packed channels; ties resolve to the
// lowest channel index because only strict improvements replace the winner.
module sel_n
  import pulse_sel_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT,
  localparam int IW = idx_width(N)
) (
  input  logic [N*W-1:0] x,
  input  logic           mode,
  output logic [W-1:0]   v,
  output logic [IW-1:0]  index
);

  // Add cell: carry-out of a + ~b + 1 is set exactly when a >= b (unsigned).
  function automatic logic geq(input logic [W-1:0] a, input logic [W-1:0] b);
    return 1'(({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) >> W);
  endfunction

  logic [W-1:0]  best;
  logic [IW-1:0] best_idx;
  logic [W-1:0]  cand;

  always_comb begin
    best     = x[W-1:0];
    best_idx = '0;
    cand     = '0;
    for (int i = 1; i < N; i++) begin
      cand = x[i*W +: W];
      if (mode ? !geq(cand, best) : !geq(best, cand)) begin
        best     = cand;
        best_idx = IW'(i);
      end
    end
  end

  assign v     = best;
  assign index = best_idx;

endmodule

// File: rtl/pulse_sel_n.sv
// Captures the max/min of N channels once all valids are low, handshakes via
// rfd, then emits a pulse exactly V cycles long. All outputs are registered.
module pulse_sel_n
  import pulse_sel_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT,
  localparam int IW = idx_width(N)
) (
  input  logic         clock,
  input  logic         reset_,
  pulse_sel_n_if.slave bus
);

  state_t        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [IW-1:0] sel_idx_q, sel_idx_d;
  logic          rfd_q, rfd_d;
  logic          out_q, out_d;

  logic [W-1:0]  sel_v;
  logic [IW-1:0] sel_index;

  sel_n #(.N(N), .W(W)) u_sel (
    .x     (bus.x),
    .mode  (bus.mode),
    .v     (sel_v),
    .index (sel_index)
  );

  always_ff @(posedge clock) begin
    if (reset_) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sel_idx_q <= '0;
      rfd_q     <= 1'b1;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sel_idx_q <= sel_idx_d;
      rfd_q     <= rfd_d;
      out_q     <= out_d;
    end
  end

  // rfd/out are derived from the next state so they can be registered
  // without adding a cycle of lag relative to the state register.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sel_idx_d = sel_idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.dav_ == '0) begin
          state_d   = ACK;
          count_d   = sel_v;
          sel_idx_d = sel_index;
        end
      end
      ACK: begin
        if (&bus.dav_) begin
          state_d = (count_q != '0) ? PULSE : IDLE;
        end
      end
      PULSE: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end
        if (count_q <= W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rfd_d = (state_d == IDLE);
    out_d = (state_d == PULSE);
  end

  assign bus.rfd     = rfd_q;
  assign bus.out     = out_q;
  assign bus.sel_idx = sel_idx_q;

endmodule

// File: tb/tb_pulse_sel_n.sv
// Directed bench for pulse_sel_n: a vector table of full transactions plus
// hand-written sequences for partial valids, mid-pulse input changes and reset.
module tb_pulse_sel_n;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    string       name;
    logic        mode;
    logic [31:0] x;
    int          exp_sel;
    int          exp_len;
  } vec_t;

  logic clock = 1'b0;
  logic reset_ = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  pulse_sel_n_if #(.N(N), .W(W)) bus ();

  pulse_sel_n #(.N(N), .W(W)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [7:0] b0, b1, b2, b3;
    b0 = c0[7:0];
    b1 = c1[7:0];
    b2 = c2[7:0];
    b3 = c3[7:0];
    return {b3, b2, b1, b0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic m, input logic [31:0] xv, input logic [N-1:0] dv);
    bus.mode = m;
    bus.x    = xv;
    bus.dav_ = dv;
  endtask

  // Releases all valids after a capture and measures the pulse up to the
  // return to IDLE, including the one-cycle release-to-pulse latency.
  task automatic finish_txn(input string name, input int exp_sel, input int exp_len);
    int  len = 0;
    bit  done = 0;
    bus.dav_ = '1;
    for (int c = 0; c < 400; c++) begin
      step();
      if (c == 0) check_output({name, " latency"}, int'(bus.out), (exp_len != 0) ? 1 : 0);
      if (bus.out) len++;
      if (bus.rfd) begin
        done = 1;
        break;
      end
    end
    check_output({name, " done"}, int'(done), 1);
    check_output({name, " len"}, len, exp_len);
    check_output({name, " out_idle"}, int'(bus.out), 0);
    check_output({name, " sel_hold"}, int'(bus.sel_idx), exp_sel);
  endtask

  task automatic run_txn(input string name, input logic m, input logic [31:0] xv,
                         input int exp_sel, input int exp_len);
    apply_stimulus(m, xv, '0);
    step();
    check_output({name, " rfd_ack"}, int'(bus.rfd), 0);
    check_output({name, " sel"}, int'(bus.sel_idx), exp_sel);
    finish_txn(name, exp_sel, exp_len);
  endtask

  vec_t vecs[8];

  initial begin
    int len;

    vecs[0] = '{"max_tie",    1'b0, pack4(10, 200, 7, 200), 1, 200};
    vecs[1] = '{"min_tie",    1'b1, pack4(9, 3, 3, 250),    1, 3};
    vecs[2] = '{"min_zero",   1'b1, pack4(0, 5, 6, 7),      0, 0};
    vecs[3] = '{"max_all255", 1'b0, pack4(255, 255, 255, 255), 0, 255};
    vecs[4] = '{"max_last",   1'b0, pack4(1, 2, 3, 4),      3, 4};
    vecs[5] = '{"min_ch2",    1'b1, pack4(7, 8, 2, 9),      2, 2};
    vecs[6] = '{"max_uns",    1'b0, pack4(128, 127, 1, 0),  0, 128};
    vecs[7] = '{"max_zeros",  1'b0, pack4(0, 0, 0, 0),      0, 0};

    // Reset with all valids low: nothing must be captured while in reset.
    apply_stimulus(1'b0, pack4(5, 6, 7, 8), '0);
    reset_ = 1'b1;
    step();
    step();
    check_output("rst rfd", int'(bus.rfd), 1);
    check_output("rst out", int'(bus.out), 0);
    check_output("rst sel", int'(bus.sel_idx), 0);
    reset_ = 1'b0;
    step();
    check_output("first_edge rfd", int'(bus.rfd), 0);
    check_output("first_edge sel", int'(bus.sel_idx), 3);
    finish_txn("first_edge", 3, 8);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].name, vecs[i].mode, vecs[i].x, vecs[i].exp_sel, vecs[i].exp_len);
      step();
    end

    // Partial valids in IDLE must not capture.
    apply_stimulus(1'b0, pack4(1, 2, 3, 4), 4'b1010);
    for (int c = 0; c < 10; c++) begin
      step();
      check_output("partial_idle rfd", int'(bus.rfd), 1);
    end
    run_txn("partial_idle", 1'b0, pack4(60, 20, 90, 30), 2, 90);

    // Partial release in ACK must hold ACK.
    apply_stimulus(1'b1, pack4(9, 3, 3, 250), '0);
    step();
    bus.dav_ = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      step();
      check_output("partial_ack rfd", int'(bus.rfd), 0);
      check_output("partial_ack out", int'(bus.out), 0);
    end
    finish_txn("partial_ack", 1, 3);

    // Inputs changing mid-pulse must not alter the pulse length.
    apply_stimulus(1'b0, pack4(50, 1, 1, 1), '0);
    step();
    bus.dav_ = '1;
    len = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (c == 5) apply_stimulus(1'b1, '1, '0);
      if (c == 10) bus.dav_ = '1;
      if (bus.out) len++;
      if (bus.rfd) break;
    end
    check_output("midpulse len", len, 50);
    check_output("midpulse sel", int'(bus.sel_idx), 0);

    // Reset in the middle of a 200-cycle pulse.
    apply_stimulus(1'b0, pack4(10, 200, 7, 200), '0);
    step();
    bus.dav_ = '1;
    len = 0;
    for (int c = 0; c < 100 && len < 50; c++) begin
      step();
      if (bus.out) len++;
    end
    check_output("rst_pulse reached", len, 50);
    reset_ = 1'b1;
    step();
    check_output("rst_pulse out", int'(bus.out), 0);
    check_output("rst_pulse rfd", int'(bus.rfd), 1);
    check_output("rst_pulse sel", int'(bus.sel_idx), 0);
    reset_ = 1'b0;
    run_txn("after_rst", 1'b1, pack4(9, 3, 3, 250), 1, 3);

    // Reset while waiting in ACK.
    apply_stimulus(1'b0, pack4(4, 9, 2, 1), '0);
    step();
    check_output("rst_ack sel", int'(bus.sel_idx), 1);
    bus.dav_ = '1;
    reset_ = 1'b1;
    step();
    check_output("rst_ack rfd", int'(bus.rfd), 1);
    check_output("rst_ack sel0", int'(bus.sel_idx), 0);
    reset_ = 1'b0;
    step();
    check_output("rst_ack idle", int'(bus.rfd), 1);
    check_output("rst_ack out", int'(bus.out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
